// File: rtl/user_time_editor.sv
// Push-button editor for the clock/date and timer BCD fields.
// Seeds from the RTC on entry and requests a commit on exit.
module user_time_editor #(
    parameter int LEAP_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       En_Escr,
    input  logic       En_clock,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [7:0] seg_RTC,
    input  logic [7:0] min_RTC,
    input  logic [7:0] hora_RTC,
    input  logic [7:0] dia_RTC,
    input  logic [7:0] mes_RTC,
    input  logic [7:0] ano_RTC,
    input  logic [7:0] seg_T_RTC,
    input  logic [7:0] min_T_RTC,
    input  logic [7:0] hora_T_RTC,
    output logic [7:0] seg_usu,
    output logic [7:0] min_usu,
    output logic [7:0] hora_usu,
    output logic [7:0] dia_usu,
    output logic [7:0] mes_usu,
    output logic [7:0] ano_usu,
    output logic [7:0] seg_T_usu,
    output logic [7:0] min_T_usu,
    output logic [7:0] hora_T_usu,
    output logic [2:0] cursor,
    output logic       write_req
);

    typedef enum logic [1:0] {S_IDLE, S_SEED, S_EDIT} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_escr_d, r_clk_d, r_wreq;
    logic [2:0] r_cursor, w_cursor_n;
    logic [7:0] r_seg, r_min, r_hora, r_dia, r_mes, r_ano;
    logic [7:0] r_segt, r_mint, r_horat;
    logic [7:0] w_seg_n, w_min_n, w_hora_n, w_dia_n, w_mes_n, w_ano_n;
    logic [7:0] w_segt_n, w_mint_n, w_horat_n;
    logic [7:0] w_dmax;
    logic [2:0] w_cmax;
    logic       w_wreq_n;

    wire w_rise = En_Escr & ~r_escr_d;
    wire w_tog  = En_clock ^ r_clk_d;
    wire w_up   = btn_up & ~btn_down;
    wire w_dn   = btn_down & ~btn_up;
    wire w_rt   = btn_right & ~btn_left;
    wire w_lf   = btn_left & ~btn_right;
    wire w_act  = (r_state == S_EDIT) && En_Escr;

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Invalid or out-of-range values snap to lo on up, hi on down.
    function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi,
                                            input logic       up);
        logic bad;
        bad = !bcd_ok(v) || (v < lo) || (v > hi);
        if (up) begin
            if (bad || v == hi) return lo;
            if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
            return v + 8'd1;
        end
        if (bad || v == lo) return hi;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    // BCD year TU is a multiple of 4 when (2T+U) mod 4 == 0.
    function automatic logic is_leap(input logic [7:0] a);
        logic [3:0] u;
        u = a[3:0];
        if (a[4]) return (u == 4'd2) || (u == 4'd6);
        return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
    endfunction

    function automatic logic [7:0] day_max(input logic [7:0] m,
                                           input logic [7:0] a);
        case (m)
            8'h02:   return (LEAP_EN != 0 && is_leap(a)) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default: return 8'h31;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_rise) w_state_nxt = S_SEED;
            S_SEED:  w_state_nxt = S_EDIT;
            S_EDIT:  if (!En_Escr) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_seg_n    = r_seg;
        w_min_n    = r_min;
        w_hora_n   = r_hora;
        w_dia_n    = r_dia;
        w_mes_n    = r_mes;
        w_ano_n    = r_ano;
        w_segt_n   = r_segt;
        w_mint_n   = r_mint;
        w_horat_n  = r_horat;
        w_cursor_n = r_cursor;
        w_wreq_n   = 1'b0;
        w_dmax     = 8'h31;
        w_cmax     = En_clock ? 3'd5 : 3'd2;
        if (r_state == S_SEED) begin
            w_seg_n    = seg_RTC;
            w_min_n    = min_RTC;
            w_hora_n   = hora_RTC;
            w_dia_n    = dia_RTC;
            w_mes_n    = mes_RTC;
            w_ano_n    = ano_RTC;
            w_segt_n   = seg_T_RTC;
            w_mint_n   = min_T_RTC;
            w_horat_n  = hora_T_RTC;
            w_cursor_n = 3'd0;
        end else if (r_state == S_EDIT && !En_Escr) begin
            w_wreq_n = 1'b1;
        end else if (w_act && w_tog) begin
            w_cursor_n = 3'd0;
        end else if (w_act) begin
            if (w_up || w_dn) begin
                if (En_clock) begin
                    case (r_cursor)
                        3'd0: w_seg_n  = bcd_step(r_seg, 8'h00, 8'h59, w_up);
                        3'd1: w_min_n  = bcd_step(r_min, 8'h00, 8'h59, w_up);
                        3'd2: w_hora_n = bcd_step(r_hora, 8'h00, 8'h23, w_up);
                        3'd3: w_dia_n  = bcd_step(r_dia, 8'h01,
                                                  day_max(r_mes, r_ano), w_up);
                        3'd4: w_mes_n  = bcd_step(r_mes, 8'h01, 8'h12, w_up);
                        3'd5: w_ano_n  = bcd_step(r_ano, 8'h00, 8'h99, w_up);
                        default: ;
                    endcase
                    // A month or year change may shorten the month.
                    w_dmax = day_max(w_mes_n, w_ano_n);
                    if ((r_cursor == 3'd4 || r_cursor == 3'd5) && r_dia > w_dmax)
                        w_dia_n = w_dmax;
                end else begin
                    case (r_cursor)
                        3'd0: w_segt_n  = bcd_step(r_segt, 8'h00, 8'h59, w_up);
                        3'd1: w_mint_n  = bcd_step(r_mint, 8'h00, 8'h59, w_up);
                        3'd2: w_horat_n = bcd_step(r_horat, 8'h00, 8'h23, w_up);
                        default: ;
                    endcase
                end
            end
            if (w_rt)
                w_cursor_n = (r_cursor >= w_cmax) ? 3'd0 : r_cursor + 3'd1;
            else if (w_lf)
                w_cursor_n = (r_cursor == 3'd0 || r_cursor > w_cmax) ?
                             w_cmax : r_cursor - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_escr_d <= 1'b0;
            r_clk_d  <= 1'b0;
            r_wreq   <= 1'b0;
            r_cursor <= 3'd0;
            r_seg    <= 8'h00;
            r_min    <= 8'h00;
            r_hora   <= 8'h00;
            r_dia    <= 8'h01;
            r_mes    <= 8'h01;
            r_ano    <= 8'h00;
            r_segt   <= 8'h00;
            r_mint   <= 8'h00;
            r_horat  <= 8'h00;
        end else begin
            r_escr_d <= En_Escr;
            r_clk_d  <= En_clock;
            r_wreq   <= w_wreq_n;
            r_cursor <= w_cursor_n;
            r_seg    <= w_seg_n;
            r_min    <= w_min_n;
            r_hora   <= w_hora_n;
            r_dia    <= w_dia_n;
            r_mes    <= w_mes_n;
            r_ano    <= w_ano_n;
            r_segt   <= w_segt_n;
            r_mint   <= w_mint_n;
            r_horat  <= w_horat_n;
        end
    end

    assign seg_usu    = r_seg;
    assign min_usu    = r_min;
    assign hora_usu   = r_hora;
    assign dia_usu    = r_dia;
    assign mes_usu    = r_mes;
    assign ano_usu    = r_ano;
    assign seg_T_usu  = r_segt;
    assign min_T_usu  = r_mint;
    assign hora_T_usu = r_horat;
    assign cursor     = r_cursor;
    assign write_req  = r_wreq;

endmodule
